// File: rtl/sha1_pkg.sv
// ---------------------------------------------------------------------------
// sha1_pkg
// Shared constants and helpers for the SHA-1 compression engine:
//   - initial hash value IV (H0..H4) and the four round constants K0..K3
//   - FSM state encoding used by sha1_core
//   - rotate helpers, the per-round logical function f(t) and K(t) selection
//   - a word-wise mod 2^32 adder for the final H + {a,b,c,d,e} step
// ---------------------------------------------------------------------------
package sha1_pkg;

  localparam logic [31:0] IV_H0 = 32'h67452301;
  localparam logic [31:0] IV_H1 = 32'hefcdab89;
  localparam logic [31:0] IV_H2 = 32'h98badcfe;
  localparam logic [31:0] IV_H3 = 32'h10325476;
  localparam logic [31:0] IV_H4 = 32'hc3d2e1f0;
  localparam logic [159:0] SHA1_IV = {IV_H0, IV_H1, IV_H2, IV_H3, IV_H4};

  localparam logic [31:0] K0 = 32'h5a827999;
  localparam logic [31:0] K1 = 32'h6ed9eba1;
  localparam logic [31:0] K2 = 32'h8f1bbcdc;
  localparam logic [31:0] K3 = 32'hca62c1d6;

  localparam logic [6:0] LAST_ROUND = 7'd79;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } sha1_state_t;

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  function automatic logic [31:0] rotl5(input logic [31:0] x);
    return {x[26:0], x[31:27]};
  endfunction

  function automatic logic [31:0] rotl30(input logic [31:0] x);
    return {x[1:0], x[31:2]};
  endfunction

  // Ch for rounds 0..19, Parity 20..39, Maj 40..59, Parity 60..79
  function automatic logic [31:0] f_round(input logic [6:0] t, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    if (t < 7'd20)      return (b & c) | (~b & d);
    else if (t < 7'd40) return b ^ c ^ d;
    else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
    else                return b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_round(input logic [6:0] t);
    if (t < 7'd20)      return K0;
    else if (t < 7'd40) return K1;
    else if (t < 7'd60) return K2;
    else                return K3;
  endfunction

  // Five independent 32-bit additions, no carry between words
  function automatic logic [159:0] add_words(input logic [159:0] x, input logic [159:0] y);
    logic [159:0] r;
    for (int i = 0; i < 5; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha1_wsched.sv
// ---------------------------------------------------------------------------
// sha1_wsched
// SHA-1 message schedule as a 16x32 circular buffer indexed by t[3:0].
// For t < 16 the stored word is returned directly; for t >= 16 the expanded
// word rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) is returned combinationally and
// written back over W[t-16] (same slot, t[3:0]) when advance is asserted.
// Ports:
//   wb_clk_i  clock
//   clear     synchronous clear of the whole buffer (has priority)
//   load      capture data; W[0]=data[511:480] .. W[15]=data[31:0]
//   data      512-bit message block
//   t         current round index 0..79
//   advance   round t is being executed this cycle
//   w         W[t] for the current round
// ---------------------------------------------------------------------------
module sha1_wsched
  import sha1_pkg::*;
(
  input  logic         wb_clk_i,
  input  logic         clear,
  input  logic         load,
  input  logic [511:0] data,
  input  logic [6:0]   t,
  input  logic         advance,
  output logic [31:0]  w
);

  logic [31:0] wbuf [16];
  logic [3:0]  i0, i3, i8, i14;
  logic [31:0] w_new;

  // Slot offsets wrap mod 16, so t-16 aliases the slot of t itself
  assign i0  = t[3:0];
  assign i3  = t[3:0] - 4'd3;
  assign i8  = t[3:0] - 4'd8;
  assign i14 = t[3:0] - 4'd14;

  assign w_new = rotl1(wbuf[i3] ^ wbuf[i8] ^ wbuf[i14] ^ wbuf[i0]);
  assign w     = (t < 7'd16) ? wbuf[i0] : w_new;

  always_ff @(posedge wb_clk_i) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) wbuf[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) wbuf[i] <= data[511-32*i -: 32];
    end else if (advance && (t >= 7'd16)) begin
      wbuf[i0] <= w_new;
    end
  end

endmodule

// File: rtl/sha1_core.sv
// ---------------------------------------------------------------------------
// sha1_core
// SHA-1 compression engine, one round per clock. A start_i pulse in IDLE or
// DONE captures message_i, loads H and a..e, then runs rounds 0..79, a FINAL
// cycle adding the working variables into H, and parks in DONE with the
// digest held on digest_o.
// Configuration macro: SHA1_MULTIBLOCK_EN
//   defined   : H loads IV only when first_i=1, otherwise chains the previous
//               digest, allowing multi-block messages
//   undefined : first_i ignored, H loads IV on every start
// Ports:
//   wb_clk_i    clock
//   reset       synchronous active-high reset
//   soft_rst_i  software reset, same effect as reset, beats start_i
//   start_i     one-cycle start pulse, samples message_i
//   first_i     first block of message (multi-block build only)
//   message_i   512-bit block, W[0] in [511:480]
//   digest_o    H0..H4, H0 in [159:128]; valid while done_o=1
//   done_o      digest ready
//   busy_o      rounds or final add in progress
//   panic_o     sticky flag: start_i arrived while busy
//   loop_idx_o  current round 0..79, holds 79 after completion
// ---------------------------------------------------------------------------
module sha1_core
  import sha1_pkg::*;
(
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         soft_rst_i,
  input  logic         start_i,
  input  logic         first_i,
  input  logic [511:0] message_i,
  output logic [159:0] digest_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         panic_o,
  output logic [6:0]   loop_idx_o
);

  sha1_state_t  state;
  logic [31:0]  a, b, c, d, e;
  logic [159:0] h_q;
  logic [159:0] h_start;
  logic [159:0] h_next;
  logic [31:0]  w_t;
  logic [31:0]  temp;
  logic         clr;
  logic         accept;

  assign clr    = reset | soft_rst_i;
  assign accept = start_i && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef SHA1_MULTIBLOCK_EN
  assign h_start = first_i ? SHA1_IV : h_q;
`else
  logic unused_first;
  assign unused_first = first_i;
  assign h_start      = SHA1_IV;
`endif

  sha1_wsched u_wsched (
    .wb_clk_i (wb_clk_i),
    .clear    (clr),
    .load     (accept),
    .data     (message_i),
    .t        (loop_idx_o),
    .advance  (state == ST_ROUND),
    .w        (w_t)
  );

  assign temp   = rotl5(a) + f_round(loop_idx_o, b, c, d) + e + k_round(loop_idx_o) + w_t;
  assign h_next = add_words(h_q, {a, b, c, d, e});

  always_ff @(posedge wb_clk_i) begin
    if (clr) begin
      state      <= ST_IDLE;
      h_q        <= '0;
      digest_o   <= '0;
      done_o     <= 1'b0;
      busy_o     <= 1'b0;
      panic_o    <= 1'b0;
      loop_idx_o <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // digest_o is left alone here so DONE keeps showing the old hash
          if (start_i) begin
            h_q             <= h_start;
            {a, b, c, d, e} <= h_start;
            loop_idx_o      <= '0;
            done_o          <= 1'b0;
            busy_o          <= 1'b1;
            state           <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          if (start_i) panic_o <= 1'b1;
          e <= d;
          d <= c;
          c <= rotl30(b);
          b <= a;
          a <= temp;
          if (loop_idx_o == LAST_ROUND) state <= ST_FINAL;
          else loop_idx_o <= loop_idx_o + 7'd1;
        end
        ST_FINAL: begin
          if (start_i) panic_o <= 1'b1;
          h_q      <= h_next;
          digest_o <= h_next;
          done_o   <= 1'b1;
          busy_o   <= 1'b0;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_core.sv
module tb_sha1_core;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         soft_rst = 1'b0;
  logic         start = 1'b0;
  logic         first = 1'b0;
  logic [511:0] msg = '0;
  logic [159:0] digest_o;
  logic         done_o, busy_o, panic_o;
  logic [6:0]   loop_idx_o;

  always #5 clk = ~clk;

  sha1_core dut (
    .wb_clk_i   (clk),
    .reset      (reset),
    .soft_rst_i (soft_rst),
    .start_i    (start),
    .first_i    (first),
    .message_i  (msg),
    .digest_o   (digest_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .panic_o    (panic_o),
    .loop_idx_o (loop_idx_o)
  );

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] MSG_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MSG_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Straightforward SHA-1 compression with a full 80-word schedule
  function automatic logic [159:0] sha1_block(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, x, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      x = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {x[30:0], x[31]};
    end
    {a, b, c, d, e} = h;
    for (int t = 0; t < 80; t++) begin
      case (t / 20)
        0:       begin f = (b & c) | (~b & d);           k = 32'h5a827999; end
        1:       begin f = b ^ c ^ d;                    k = 32'h6ed9eba1; end
        2:       begin f = (b & c) | (b & d) | (c & d);  k = 32'h8f1bbcdc; end
        default: begin f = b ^ c ^ d;                    k = 32'hca62c1d6; end
      endcase
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Observable behaviour model: counts edges since an accepted start
  logic [159:0] m_digest = '0, m_h = '0, m_pending = '0, hsel;
  logic         m_busy = 1'b0, m_done = 1'b0, m_panic = 1'b0;
  int           m_idx = 0, m_cnt = 0;

  always @(posedge clk) begin
    if (reset || soft_rst) begin
      m_digest = '0; m_h = '0; m_busy = 1'b0; m_done = 1'b0; m_panic = 1'b0;
      m_idx = 0; m_cnt = 0;
    end else if (start && !m_busy) begin
`ifdef SHA1_MULTIBLOCK_EN
      hsel = first ? IV : m_h;
`else
      hsel = IV;
`endif
      m_h = hsel;
      m_pending = sha1_block(hsel, msg);
      m_busy = 1'b1; m_done = 1'b0; m_idx = 0; m_cnt = 0;
    end else begin
      if (start) m_panic = 1'b1;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == 81) begin
          m_busy = 1'b0; m_done = 1'b1; m_digest = m_pending; m_h = m_pending;
        end else begin
          m_idx = (m_cnt < 79) ? m_cnt : 79;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_digest", digest_o, m_digest);
      check("cyc_done", 160'(done_o), 160'(m_done));
      check("cyc_busy", 160'(busy_o), 160'(m_busy));
      check("cyc_panic", 160'(panic_o), 160'(m_panic));
      check("cyc_loop_idx", 160'(loop_idx_o), 160'(m_idx));
    end
  end

  task automatic pulse_start(input logic [511:0] m, input logic f);
    @(negedge clk); start = 1'b1; msg = m; first = f;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns number of negedges waited after the start pulse until done_o
  task automatic wait_done(input string name, output int cnt);
    cnt = 0;
    while (!done_o && cnt < 200) begin
      @(negedge clk); cnt++;
    end
    if (!done_o) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: done_o=0 after %0d cycles, required 1", name, cnt);
    end
  endtask

  task automatic run_block(input string name, input logic [511:0] m, input logic f,
                           input logic [159:0] exp);
    int cnt;
    pulse_start(m, f);
    wait_done(name, cnt);
    // start sampled at edge N; done visible after edge N+81
    check({name, "_latency"}, 160'(cnt), 160'(81));
    check({name, "_digest"}, digest_o, exp);
    check({name, "_loop_idx"}, 160'(loop_idx_o), 160'(79));
  endtask

  initial begin
    int cnt;
    check("model_abc", sha1_block(IV, MSG_ABC), DIG_ABC);
    check("model_empty", sha1_block(IV, MSG_EMPTY), DIG_EMPTY);
    check("model_two", sha1_block(sha1_block(IV, MSG_TWO1), MSG_TWO2), DIG_TWO);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_outputs", {digest_o, done_o, busy_o, panic_o}, 163'h0);
    check("rst_loop_idx", 160'(loop_idx_o), 160'(0));

    run_block("abc", MSG_ABC, 1'b1, DIG_ABC);
    // started from DONE: old digest stays until FINAL (checked every cycle)
    run_block("empty", MSG_EMPTY, 1'b1, DIG_EMPTY);

`ifdef SHA1_MULTIBLOCK_EN
    run_block("two_blk1", MSG_TWO1, 1'b1, sha1_block(IV, MSG_TWO1));
    run_block("two_blk2", MSG_TWO2, 1'b0, DIG_TWO);
`endif

    // second start while busy is ignored but flagged
    pulse_start(MSG_ABC, 1'b1);
    repeat (9) @(negedge clk);
    pulse_start(MSG_EMPTY, 1'b1);
    check("panic_set", 160'(panic_o), 160'(1));
    wait_done("panic_run", cnt);
    check("panic_digest", digest_o, DIG_ABC);
    check("panic_sticky", 160'(panic_o), 160'(1));

    // idle with panic set still accepts a start
    run_block("after_panic", MSG_EMPTY, 1'b1, DIG_EMPTY);

    // reset mid-run
    pulse_start(MSG_ABC, 1'b1);
    repeat (39) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("midrst_outputs", {digest_o, done_o, busy_o, panic_o}, 163'h0);
    check("midrst_loop_idx", 160'(loop_idx_o), 160'(0));
    run_block("rerun_abc", MSG_ABC, 1'b1, DIG_ABC);
    check("rerun_panic", 160'(panic_o), 160'(0));

    // soft reset beats simultaneous start
    @(negedge clk); soft_rst = 1'b1; start = 1'b1; msg = MSG_ABC;
    @(negedge clk); soft_rst = 1'b0; start = 1'b0;
    check("soft_busy", 160'(busy_o), 160'(0));
    check("soft_done", 160'(done_o), 160'(0));
    check("soft_digest", digest_o, 160'h0);
    repeat (3) @(negedge clk);
    check("soft_stays_idle", 160'(busy_o), 160'(0));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
